// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: FSM states, rule bit positions
// and the control part of the per-transfer reference snapshot.
package apb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int ERR_W                 = 7;
    localparam int ERR_SETUP_NO_ACCESS   = 0;
    localparam int ERR_UNSTABLE          = 1;
    localparam int ERR_ENABLE_NO_SEL     = 2;
    localparam int ERR_SEL_MULTI         = 3;
    localparam int ERR_TIMEOUT           = 4;
    localparam int ERR_READ_STRB         = 5;
    localparam int ERR_ENABLE_AFTER_DONE = 6;

    typedef struct packed {
        logic [2:0] prot;
        logic       nse;
        logic       write;
    } snap_ctrl_t;

endpackage

// File: rtl/apb_mon_sat_counter.sv
// Saturating up-counter: one cycle from inc_i to cnt_o, sticks at all-ones.
// No backpressure; synchronous active-high reset.
module apb_mon_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB4/APB5 checker: rule pulses one cycle after the offending bus cycle,
// sticky status/first-error capture one cycle later; never drives or stalls the bus.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SEL    = 1,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic                    pnse,
    input  logic [NUM_SEL-1:0]      psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic                    err_clr,
    output logic [ERR_W-1:0]        err_pulse,
    output logic [ERR_W-1:0]        err_sticky,
    output logic                    irq,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic [ERR_W-1:0]        err_code,
    output logic [CNT_WIDTH-1:0]    wr_cnt,
    output logic [CNT_WIDTH-1:0]    rd_cnt,
    output logic [CNT_WIDTH-1:0]    slverr_cnt
);

    localparam int WW = $clog2(MAX_WAIT + 2);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [NUM_SEL-1:0]      sel;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        snap_ctrl_t              ctrl;
    } snap_t;

    apb_state_e            state_q, state_d, phase;
    snap_t                 snap_q, snap_d;
    logic [WW-1:0]         wait_q, wait_d, wait_base, wait_inc;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q, err_addr_q;
    logic [ERR_W-1:0]      rules, err_pulse_q, err_sticky_q, err_code_q;
    logic                  any_sel, completion, unstable, capture;

    // state_q is the phase the bus owes us this cycle; phase is what it actually is.
    always_comb begin
        any_sel = |psel;
        phase   = IDLE;
        case (state_q)
            SETUP:   phase = any_sel ? (penable ? ACCESS : SETUP) : IDLE;
            ACCESS:  phase = ACCESS;
            default: phase = (any_sel && !penable) ? SETUP : IDLE;
        endcase
        completion = (phase == ACCESS) && pready;
        state_d    = completion ? IDLE : phase;

        snap_d = snap_q;
        if (phase == SETUP) begin
            snap_d.addr       = paddr;
            snap_d.sel        = psel;
            snap_d.data       = pwdata;
            snap_d.strb       = pstrb;
            snap_d.ctrl.prot  = pprot;
            snap_d.ctrl.nse   = pnse;
            snap_d.ctrl.write = pwrite;
        end

        // Count saturates at MAX_WAIT so the equality can only be crossed once.
        wait_base = (state_q == SETUP) ? '0 : wait_q;
        wait_inc  = wait_base + 1'b1;
        wait_d    = '0;
        if (phase == ACCESS) begin
            wait_d = (!pready && (wait_base != WW'(MAX_WAIT))) ? wait_inc : wait_base;
        end

        unstable = (paddr != snap_q.addr) || (psel != snap_q.sel) ||
                   (pprot != snap_q.ctrl.prot) || (pnse != snap_q.ctrl.nse) ||
                   (pwrite != snap_q.ctrl.write) || (pstrb != snap_q.strb) ||
                   (snap_q.ctrl.write && (pwdata != snap_q.data));

        rules                        = '0;
        rules[ERR_SETUP_NO_ACCESS]   = (state_q == SETUP) && !(any_sel && penable);
        rules[ERR_UNSTABLE]          = (phase == ACCESS) && unstable;
        rules[ERR_ENABLE_NO_SEL]     = penable && !any_sel;
        rules[ERR_SEL_MULTI]         = (psel & (psel - 1'b1)) != '0;
        rules[ERR_TIMEOUT]           = (MAX_WAIT != 0) && (phase == ACCESS) && !pready &&
                                       (wait_inc == WW'(MAX_WAIT));
        rules[ERR_READ_STRB]         = (phase == ACCESS) && !pwrite && (pstrb != '0);
        rules[ERR_ENABLE_AFTER_DONE] = done_q && penable;
    end

    assign capture = (err_pulse_q != '0) && ((err_sticky_q == '0) || err_clr);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            wait_q       <= '0;
            done_q       <= 1'b0;
            pend_addr_q  <= '0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
            err_code_q   <= '0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            wait_q       <= wait_d;
            done_q       <= completion;
            // Address travels with the pulse so capture reports the offending cycle.
            pend_addr_q  <= (state_q != IDLE) ? snap_q.addr : paddr;
            err_pulse_q  <= rules;
            err_sticky_q <= err_clr ? err_pulse_q : (err_sticky_q | err_pulse_q);
            if (capture) begin
                err_code_q <= err_pulse_q;
                err_addr_q <= pend_addr_q;
            end
        end
    end

    apb_mon_sat_counter #(.W(CNT_WIDTH)) u_wr_cnt (
        .clk_i (pclk),
        .rst_i (preset),
        .inc_i (completion && pwrite),
        .cnt_o (wr_cnt)
    );

    apb_mon_sat_counter #(.W(CNT_WIDTH)) u_rd_cnt (
        .clk_i (pclk),
        .rst_i (preset),
        .inc_i (completion && !pwrite),
        .cnt_o (rd_cnt)
    );

    apb_mon_sat_counter #(.W(CNT_WIDTH)) u_slverr_cnt (
        .clk_i (pclk),
        .rst_i (preset),
        .inc_i (completion && pslverr),
        .cnt_o (slverr_cnt)
    );

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign irq        = |err_sticky_q;
    assign err_code   = err_code_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Randomised bench for apb_protocol_monitor: a transfer-level reference model feeds
// a scoreboard queue that a separate monitor drains every cycle.
module tb_apb_protocol_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int MW = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic [2:0]    pprot = '0;
    logic          pnse = 1'b0;
    logic [NS-1:0] psel = '0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          err_clr = 1'b0;
    logic [6:0]    err_pulse, err_sticky, err_code;
    logic          irq;
    logic [AW-1:0] err_addr;
    logic [CW-1:0] wr_cnt, rd_cnt, slverr_cnt;

    apb_protocol_monitor #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SEL    (NS),
        .MAX_WAIT   (MW),
        .CNT_WIDTH  (CW)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .paddr      (paddr),
        .pprot      (pprot),
        .pnse       (pnse),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .pslverr    (pslverr),
        .err_clr    (err_clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .irq        (irq),
        .err_addr   (err_addr),
        .err_code   (err_code),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt),
        .slverr_cnt (slverr_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [6:0]    pulse;
        logic [6:0]    sticky;
        logic          irq;
        logic [6:0]    code;
        logic [AW-1:0] addr;
        logic [CW-1:0] wr;
        logic [CW-1:0] rd;
        logic [CW-1:0] slv;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: bus phase is classified from what the previous cycle promised.
    logic [6:0]    m_pulse = '0, m_sticky = '0, m_code = '0;
    logic [AW-1:0] m_addr = '0, m_pend = '0;
    int            m_wr = 0, m_rd = 0, m_slv = 0, m_waits = 0;
    bit            m_exp_acc = 0, m_in_acc = 0, m_prev_done = 0;
    logic [AW-1:0] s_addr;
    logic [NS-1:0] s_sel;
    logic [2:0]    s_prot;
    logic          s_nse, s_write;
    logic [DW-1:0] s_data;
    logic [3:0]    s_strb;

    always @(posedge pclk) begin : model
        logic [6:0] r;
        bit sel, first, acc, setup, done;
        exp_t e;
        if (preset) begin
            m_pulse = '0; m_sticky = '0; m_code = '0; m_addr = '0; m_pend = '0;
            m_wr = 0; m_rd = 0; m_slv = 0; m_waits = 0;
            m_exp_acc = 0; m_in_acc = 0; m_prev_done = 0;
            s_addr = '0; s_sel = '0; s_prot = '0; s_nse = 0; s_write = 0; s_data = '0; s_strb = '0;
        end else begin
            sel   = (psel != 0);
            first = m_exp_acc && sel && penable;
            acc   = m_in_acc || first;
            setup = !acc && sel && !penable;
            done  = acc && pready;
            r     = '0;
            r[0]  = m_exp_acc && !(sel && penable);
            r[1]  = acc && (paddr != s_addr || psel != s_sel || pprot != s_prot ||
                            pnse != s_nse || pwrite != s_write || pstrb != s_strb ||
                            (s_write && pwdata != s_data));
            r[2]  = penable && !sel;
            r[3]  = $countones(psel) > 1;
            if (first) m_waits = 0;
            if (acc && !pready) begin
                m_waits++;
                r[4] = (m_waits == MW);
            end
            r[5]  = acc && !pwrite && (pstrb != 0);
            r[6]  = m_prev_done && penable;

            if (m_pulse != 0 && (m_sticky == 0 || err_clr)) begin
                m_code = m_pulse;
                m_addr = m_pend;
            end
            m_sticky = err_clr ? m_pulse : (m_sticky | m_pulse);
            m_pend   = (m_exp_acc || m_in_acc) ? s_addr : paddr;
            m_pulse  = r;
            if (done) begin
                if (pwrite) m_wr = (m_wr < CMAX) ? m_wr + 1 : CMAX;
                else        m_rd = (m_rd < CMAX) ? m_rd + 1 : CMAX;
                if (pslverr) m_slv = (m_slv < CMAX) ? m_slv + 1 : CMAX;
            end
            if (setup) begin
                s_addr = paddr; s_sel = psel; s_prot = pprot; s_nse = pnse;
                s_write = pwrite; s_data = pwdata; s_strb = pstrb;
            end
            m_exp_acc   = setup;
            m_in_acc    = acc && !pready;
            m_prev_done = done;
        end
        e.pulse  = m_pulse;
        e.sticky = m_sticky;
        e.irq    = (m_sticky != 0);
        e.code   = m_code;
        e.addr   = m_addr;
        e.wr     = CW'(m_wr);
        e.rd     = CW'(m_rd);
        e.slv    = CW'(m_slv);
        sb_q.push_back(e);
    end

    always @(posedge pclk) begin : monitor
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("err_pulse",  32'(err_pulse),  32'(e.pulse));
            chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
            chk("irq",        32'(irq),        32'(e.irq));
            chk("err_code",   32'(err_code),   32'(e.code));
            chk("err_addr",   err_addr,        e.addr);
            chk("wr_cnt",     32'(wr_cnt),     32'(e.wr));
            chk("rd_cnt",     32'(rd_cnt),     32'(e.rd));
            chk("slverr_cnt", 32'(slverr_cnt), 32'(e.slv));
        end
    end

    task automatic idle(input int n);
        psel = '0; penable = 0; pready = 0; pslverr = 0; pwrite = 0; pstrb = '0; err_clr = 0;
        repeat (n) @(negedge pclk);
    endtask

    // fault: 0 none, 1 paddr+4, 2 read strobes, 4 no access, 5 penable after done,
    // 6 pwdata flip, 7 pprot flip (1/6/7 applied from the 2nd ACCESS cycle)
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input int waits,
                        input bit serr, input logic [NS-1:0] sel, input int fault);
        psel = sel; penable = 0; paddr = addr; pwrite = wr; pwdata = $urandom;
        pstrb = wr ? 4'($urandom_range(1, 15)) : ((fault == 2) ? 4'hF : 4'h0);
        pprot = 3'($urandom); pnse = 1'($urandom); pready = 0; pslverr = 0;
        @(negedge pclk);
        if (fault == 4) begin
            psel = '0; penable = 0;
            @(negedge pclk);
            return;
        end
        penable = 1;
        for (int i = 0; i <= waits; i++) begin
            pready  = (i == waits);
            pslverr = (i == waits) ? serr : 1'($urandom);
            if (i == 1) begin
                case (fault)
                    1: paddr = addr + 4;
                    6: pwdata = ~pwdata;
                    7: pprot = ~pprot;
                    default: ;
                endcase
            end
            @(negedge pclk);
        end
        if (fault == 5) begin
            pready = 0; pslverr = 0;
            @(negedge pclk);
        end
        pready = 0; pslverr = 0;
    endtask

    task automatic clear_err();
        err_clr = 1;
        @(negedge pclk);
        err_clr = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(negedge pclk);
        preset = 0;
        idle(2);

        // Legal write with two wait states, back-to-back with a read.
        xfer(1, 32'h40, 2, 0, 4'b0001, 0);
        xfer(0, 32'h80, 1, 0, 4'b0001, 0);
        idle(2);
        chk("tp1_sticky", 32'(err_sticky), 32'h0);
        chk("tp1_wr",     32'(wr_cnt), 32'd1);
        chk("tp1_rd",     32'(rd_cnt), 32'd1);
        chk("tp1_slverr", 32'(slverr_cnt), 32'd0);

        // paddr moves in the 2nd ACCESS cycle.
        xfer(1, 32'h40, 3, 0, 4'b0001, 1);
        idle(2);
        chk("tp2_code", 32'(err_code), 32'h02);
        chk("tp2_addr", err_addr, 32'h40);
        chk("tp2_irq",  32'(irq), 32'd1);
        clear_err();
        idle(2);
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        chk("clr_code_hold", 32'(err_code), 32'h02);

        // Long wait: timeout once.
        xfer(1, 32'h100, 10, 0, 4'b0001, 0);
        idle(2);
        chk("tp3_code",   32'(err_code), 32'h10);
        chk("tp3_sticky", 32'(err_sticky), 32'h10);
        clear_err();
        idle(2);

        // Multi-select, then read with strobes.
        xfer(1, 32'h200, 0, 0, 4'b0110, 0);
        xfer(0, 32'h204, 0, 0, 4'b0001, 2);
        idle(2);
        chk("tp4_sticky", 32'(err_sticky), 32'h28);
        chk("tp4_code",   32'(err_code), 32'h08);

        // err_clr coincident with ENABLE_NO_SEL.
        psel = '0; penable = 1; err_clr = 1;
        @(negedge pclk);
        idle(3);
        chk("tp5_sticky", 32'(err_sticky), 32'h04);
        chk("tp5_code",   32'(err_code), 32'h04);

        // Saturate the counters, then reset mid-ACCESS.
        for (int i = 0; i < 17; i++) begin
            xfer(1, 32'h1000 + 32'(i * 4), 0, 1, 4'b0001, 0);
            xfer(0, 32'h2000 + 32'(i * 4), 0, 1, 4'b0010, 0);
        end
        idle(1);
        chk("sat_wr",  32'(wr_cnt), CMAX);
        chk("sat_rd",  32'(rd_cnt), CMAX);
        chk("sat_slv", 32'(slverr_cnt), CMAX);
        psel = 4'b0001; penable = 0; paddr = 32'h300; pwrite = 1; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1; preset = 1;
        @(negedge pclk);
        preset = 0;
        chk("rst_pulse",  32'(err_pulse), 32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);
        chk("rst_irq",    32'(irq), 32'h0);
        chk("rst_code",   32'(err_code), 32'h0);
        chk("rst_addr",   err_addr, 32'h0);
        chk("rst_wr",     32'(wr_cnt), 32'h0);
        chk("rst_rd",     32'(rd_cnt), 32'h0);
        chk("rst_slv",    32'(slverr_cnt), 32'h0);
        idle(2);
        xfer(1, 32'h304, 1, 0, 4'b0001, 0);
        idle(2);
        chk("post_rst_wr",     32'(wr_cnt), 32'd1);
        chk("post_rst_rd",     32'(rd_cnt), 32'd0);
        chk("post_rst_sticky", 32'(err_sticky), 32'h0);

        // Random traffic with occasional faults and clears.
        for (int n = 0; n < 250; n++) begin
            logic [NS-1:0] sel;
            int fault;
            sel   = ($urandom_range(0, 9) == 0) ? NS'($urandom_range(1, 15))
                                                : NS'(1 << $urandom_range(0, NS - 1));
            fault = $urandom_range(0, 15);
            if (fault > 7 || fault == 3) fault = 0;
            xfer(1'($urandom), {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 6),
                 1'($urandom), sel, fault);
            if ($urandom_range(0, 2) == 0) begin
                psel = '0; penable = 0; pready = 0;
                err_clr = ($urandom_range(0, 3) == 0);
                @(negedge pclk);
                err_clr = 0;
            end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_protocol_monitor.md
Name: apb_protocol_monitor

Overview:
- Synthesizable, parametrised APB4/APB5 protocol checker and statistics block.
- Passively taps one APB bus (NUM_SEL completer selects) and tracks every transfer with an IDLE/SETUP/ACCESS FSM.
- Flags protocol violations as per-rule pulses and sticky status, captures the first offending transfer, and keeps saturating transfer counters.
- Lives beside the APB interconnect, in silicon and in simulation, and drives a sticky IRQ for debug.

Parameters:
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width; must be 8, 16 or 32
- NUM_SEL, 1, number of psel lines, 1..16
- MAX_WAIT, 16, maximum wait states (ACCESS cycles with pready=0) before TIMEOUT; 0 disables the rule
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- paddr  in  ADDR_WIDTH  monitored address
- pprot  in  3  monitored protection
- pnse  in  1  monitored non-secure extension
- psel  in  NUM_SEL  monitored selects
- penable  in  1  monitored enable
- pwrite  in  1  monitored direction
- pwdata  in  DATA_WIDTH  monitored write data
- pstrb  in  DATA_WIDTH/8  monitored strobes
- pready  in  1  monitored ready
- pslverr  in  1  monitored error response
- err_clr  in  1  clears err_sticky and re-arms first-error capture
- err_pulse  out  7  per-rule violation, one cycle, registered
- err_sticky  out  7  OR-accumulated violations
- irq  out  1  |err_sticky
- err_addr  out  ADDR_WIDTH  paddr of the first captured violation
- err_code  out  7  err_pulse vector of the first captured violation
- wr_cnt  out  CNT_WIDTH  completed writes
- rd_cnt  out  CNT_WIDTH  completed reads
- slverr_cnt  out  CNT_WIDTH  completions with pslverr=1

Behaviour:
- Reset: one pclk edge with preset=1 drives every output to 0 and the FSM to IDLE. This applies mid-transfer too; monitoring restarts with the next SETUP.
- Terms: any_sel = |psel. A completion is ACCESS & pready.
- FSM transitions:
  - IDLE to SETUP on any_sel & ~penable.
  - SETUP to ACCESS on any_sel & penable.
  - ACCESS stays in ACCESS while ~pready.
  - On completion, ACCESS goes to SETUP if any_sel & ~penable in the same cycle is not possible on the bus, so it goes to IDLE. The next cycle's any_sel & ~penable then re-enters SETUP (back-to-back transfers are legal).
- On entry to SETUP, the block latches paddr, pprot, pnse, psel, pwrite, pwdata and pstrb into a reference snapshot.
- Rules: each rule is evaluated combinationally in cycle N; the err_pulse bit asserts in cycle N+1.
  - [0] SETUP_NO_ACCESS: in SETUP, the next cycle is not any_sel & penable.
  - [1] UNSTABLE: in ACCESS, any monitored control or address signal, pwdata (writes only) or pstrb differs from the snapshot.
  - [2] ENABLE_NO_SEL: penable & ~any_sel, in any state.
  - [3] SEL_MULTI: psel is neither zero nor one-hot; never fires when NUM_SEL=1.
  - [4] TIMEOUT: the wait counter, cleared on ACCESS entry and incremented on each ~pready ACCESS cycle, equals MAX_WAIT. Fires once per transfer; the counter saturates.
  - [5] READ_STRB: ACCESS & ~pwrite & (pstrb != 0).
  - [6] ENABLE_AFTER_DONE: penable is high in the cycle following a completion.
- Several rules may fire in the same cycle; all of their bits set together.
- err_sticky <= err_clr ? err_pulse : (err_sticky | err_pulse). A new error arriving in the same cycle as err_clr survives the clear.
- First-error capture:
  - When err_pulse != 0 and (err_sticky == 0 or err_clr), the block loads err_code <= err_pulse and err_addr <= the snapshot address. If the FSM is IDLE, err_addr takes the live paddr instead.
  - Otherwise err_code and err_addr hold.
  - err_clr alone does not clear err_addr or err_code.
- Counters: on completion, wr_cnt increments if pwrite, else rd_cnt; slverr_cnt increments if pslverr. All counters saturate at all-ones and never wrap. pslverr outside a completion is ignored.
- Monitoring is purely passive: no APB signal is driven.

Decomposition:
- Package apb_mon_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS);
  - localparam indices ERR_SETUP_NO_ACCESS..ERR_ENABLE_AFTER_DONE;
  - ERR_W=7;
  - a typedef for the snapshot struct.
- One sub-module, apb_mon_sat_counter (parametrised width, inc input, saturating), instantiated three times.

Test Plan:
- Legal write: addr 0x40, 2 wait states, pslverr=0, followed back-to-back by a read -> err_sticky=0, wr_cnt=1, rd_cnt=1, slverr_cnt=0.
- paddr changes 0x40->0x44 in the 2nd ACCESS cycle -> err_pulse=7'b0000010 one cycle later; err_addr=0x40; err_code=0x02; irq=1.
- MAX_WAIT=4 with pready held low for 10 cycles -> TIMEOUT pulses exactly once, after the 4th wait cycle.
- NUM_SEL=4, psel=4'b0110 in SETUP -> bit 3 set; a later read with pstrb=4'hF -> err_sticky=0x28, while err_code stays 0x08.
- Pulse err_clr in the same cycle as an ENABLE_NO_SEL violation -> err_sticky=0x04 and err_code reloaded to 0x04.
- Assert preset mid-ACCESS with counters at all-ones -> all outputs 0 the next cycle; a following legal transfer is counted with no errors.
